// File: rtl/bullet_manager.sv
// Per-player bullet pool: spawns on fire edges, moves bullets in 1/8-pixel fixed point,
// bounces them off screen edges and maze walls, and reports hits on the opposing tank.
module bullet_manager #(
  parameter int NUM_BULLETS  = 4,
  parameter int BULLET_SPEED = 32,
  parameter int LIFETIME     = 300,
  parameter int COOLDOWN     = 15,
  parameter int X_MAX        = 639,
  parameter int Y_MAX        = 479
) (
  input  logic                      frame_clk,
  input  logic                      Reset,
  input  logic [1:0]                game_end,
  input  logic                      ShootBullet,
  input  logic [7:0]                sin,
  input  logic [7:0]                cos,
  input  logic [9:0]                TankX,
  input  logic [9:0]                TankY,
  input  logic [9:0]                OppX,
  input  logic [9:0]                OppY,
  input  logic [9:0]                OppS,
  input  logic [NUM_BULLETS-1:0]    wall_flip_x,
  input  logic [NUM_BULLETS-1:0]    wall_flip_y,
  output logic [NUM_BULLETS-1:0]    bullet_active,
  output logic [10*NUM_BULLETS-1:0] bullet_x,
  output logic [10*NUM_BULLETS-1:0] bullet_y,
  output logic                      hit,
  output logic [2:0]                hit_slot
);

  localparam int LW = $clog2(LIFETIME + 2);
  localparam int CW = $clog2(COOLDOWN + 2);
  localparam logic [10:0] X_LIM = 11'(X_MAX);
  localparam logic [10:0] Y_LIM = 11'(Y_MAX);

  logic                   shoot_prev_reg;
  logic [CW-1:0]          cooldown_reg;
  logic                   hit_reg;
  logic [2:0]             hit_slot_reg;
  logic [NUM_BULLETS-1:0] active_vec;
  logic [NUM_BULLETS-1:0] hit_vec;
  logic                   clear;
  logic                   accept;
  logic [2:0]             spawn_idx;
  logic [2:0]             hit_idx;
  logic [19:0]            prod_x, prod_y;
  logic [12:0]            mag_x, mag_y;
  logic signed [12:0]     vx_spawn, vy_spawn;

  assign clear = Reset || (game_end != 2'b00);

  always_comb begin
    accept    = ShootBullet && !shoot_prev_reg && (cooldown_reg == '0) && !(&active_vec);
    spawn_idx = 3'd0;
    hit_idx   = 3'd0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (!active_vec[i]) spawn_idx = 3'(i);
      if (hit_vec[i])     hit_idx   = 3'(i);
    end
    prod_x   = 20'(BULLET_SPEED) * {13'd0, cos[6:0]};
    prod_y   = 20'(BULLET_SPEED) * {13'd0, sin[6:0]};
    mag_x    = prod_x[19:7];
    mag_y    = prod_y[19:7];
    vx_spawn = cos[7] ? -$signed(mag_x) : $signed(mag_x);
    // Screen y grows downward, so a positive sine moves the bullet up.
    vy_spawn = sin[7] ? $signed(mag_y) : -$signed(mag_y);
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      shoot_prev_reg <= 1'b0;
      cooldown_reg   <= '0;
      hit_reg        <= 1'b0;
      hit_slot_reg   <= 3'd0;
    end else begin
      shoot_prev_reg <= ShootBullet;
      if (clear) begin
        cooldown_reg <= '0;
        hit_reg      <= 1'b0;
        hit_slot_reg <= 3'd0;
      end else begin
        hit_reg      <= |hit_vec;
        hit_slot_reg <= hit_idx;
        if (accept)                  cooldown_reg <= CW'(COOLDOWN);
        else if (cooldown_reg != '0) cooldown_reg <= cooldown_reg - CW'(1);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BULLETS; gi++) begin : g_slot
      logic               active_reg;
      logic [12:0]        x_reg, y_reg;
      logic signed [12:0] vx_reg, vy_reg;
      logic [LW-1:0]      life_reg;
      logic signed [10:0] dx, dy;
      logic [10:0]        adx, ady;
      logic signed [12:0] vx_eff, vy_eff;
      logic signed [13:0] nx, ny;
      logic               x_out, y_out, hit_s;

      always_comb begin
        dx     = $signed({1'b0, x_reg[12:3]}) - $signed({1'b0, OppX});
        dy     = $signed({1'b0, y_reg[12:3]}) - $signed({1'b0, OppY});
        adx    = dx[10] ? -dx : dx;
        ady    = dy[10] ? -dy : dy;
        hit_s  = active_reg && (adx <= {1'b0, OppS}) && (ady <= {1'b0, OppS});
        vx_eff = wall_flip_x[gi] ? -vx_reg : vx_reg;
        vy_eff = wall_flip_y[gi] ? -vy_reg : vy_reg;
        nx     = $signed({1'b0, x_reg}) + $signed({vx_eff[12], vx_eff});
        ny     = $signed({1'b0, y_reg}) + $signed({vy_eff[12], vy_eff});
        x_out  = nx[13] || (nx[13:3] > X_LIM);
        y_out  = ny[13] || (ny[13:3] > Y_LIM);
      end

      always_ff @(posedge frame_clk) begin
        if (clear) begin
          active_reg <= 1'b0;
          x_reg      <= '0;
          y_reg      <= '0;
          vx_reg     <= '0;
          vy_reg     <= '0;
          life_reg   <= '0;
        end else if (active_reg) begin
          // Hit and expiry free the slot but leave its last position visible.
          if (hit_s || life_reg == LW'(1)) begin
            active_reg <= 1'b0;
          end else begin
            life_reg <= life_reg - LW'(1);
            if (x_out) vx_reg <= -vx_eff;
            else begin
              vx_reg <= vx_eff;
              x_reg  <= nx[12:0];
            end
            if (y_out) vy_reg <= -vy_eff;
            else begin
              vy_reg <= vy_eff;
              y_reg  <= ny[12:0];
            end
          end
        end else if (accept && spawn_idx == 3'(gi)) begin
          active_reg <= 1'b1;
          x_reg      <= {TankX, 3'b000};
          y_reg      <= {TankY, 3'b000};
          vx_reg     <= vx_spawn;
          vy_reg     <= vy_spawn;
          life_reg   <= LW'(LIFETIME);
        end
      end

      assign active_vec[gi]          = active_reg;
      assign hit_vec[gi]             = hit_s;
      assign bullet_x[10*gi +: 10]   = x_reg[12:3];
      assign bullet_y[10*gi +: 10]   = y_reg[12:3];
    end
  endgenerate

  assign bullet_active = active_vec;
  assign hit           = hit_reg;
  assign hit_slot      = hit_slot_reg;

endmodule
